// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the byte-serial RV32I/RV64I ALU.
// Op codes, FSM states, iterative-unit modes and opcode legality check.
package riscv_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h08;
    localparam logic [4:0] OP_SLL  = 5'h01;
    localparam logic [4:0] OP_SLT  = 5'h02;
    localparam logic [4:0] OP_SLTU = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_SRL  = 5'h05;
    localparam logic [4:0] OP_SRA  = 5'h0D;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_AND  = 5'h07;
    localparam logic [4:0] OP_MUL  = 5'h10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_OUT
    } state_e;

    typedef enum logic [1:0] {
        IT_SLL,
        IT_SRL,
        IT_SRA,
        IT_MUL
    } iter_mode_e;

    function automatic logic is_legal_op(logic [4:0] op, logic mul_en);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: ok = 1'b1;
            OP_MUL:  ok = mul_en;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_alu_if.sv
// Byte-stream pin bundle of the serial ALU.
// master = producer/consumer side, slave = the ALU.
interface riscv_alu_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_zero;
    logic       out_err;
    logic       busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_last, out_zero, out_err, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output out_last, out_zero, out_err, busy
    );
endinterface

// File: rtl/riscv_alu_iter.sv
// Iterative datapath: one shift position or one multiplier bit per cycle.
// The start cycle loads operands; done marks the cycle whose result is final.
module riscv_alu_iter
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  iter_mode_e      mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(XLEN + 1);

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] step;
    logic [SHW-1:0]  shamt;

    assign shamt = b[SHW-1:0];

    // One iteration of the selected operation applied to the accumulator
    always_comb begin
        step = acc_q;
        unique case (mode)
            IT_SLL:  step = acc_q << 1;
            IT_SRL:  step = acc_q >> 1;
            IT_SRA:  step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            IT_MUL:  step = mplier_q[0] ? acc_q + mcand_q : acc_q;
            default: step = acc_q;
        endcase
    end

    // Zero shift finishes in the start cycle; otherwise the final step is combinational
    always_comb begin
        done   = 1'b0;
        result = step;
        if (start) begin
            done   = (mode != IT_MUL) && (shamt == '0);
            result = a;
        end else begin
            done = (cnt_q == CNTW'(1));
        end
    end

    // Operand load on start, then step until the count runs out
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= (mode == IT_MUL) ? '0 : a;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= (mode == IT_MUL) ? CNTW'(XLEN) : CNTW'(shamt);
        end else if (cnt_q != '0) begin
            acc_q    <= step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNTW'(1);
        end
    end

endmodule

// File: rtl/riscv_alu_seq.sv
// Byte-serial RV32I/RV64I integer ALU: op byte, A, B in; result out, LSB first.
// Define RISCV_ALU_MUL_EN to enable the iterative MUL (op 0x10).
module riscv_alu_seq
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic        clk,
    input logic        rst,
    riscv_alu_if.slave bus
);

    localparam int NBYTES = XLEN / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef RISCV_ALU_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   bcnt_q;
    logic [4:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic            zero_q, err_q, first_q;

    logic            in_ready, out_valid;
    logic            in_fire, out_fire, byte_last;
    logic            legal, use_iter, exec_done;
    logic [XLEN-1:0] alu_res, exec_res, iter_res;
    iter_mode_e      mode;
    logic            iter_start, iter_done;

    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;
    assign byte_last = (bcnt_q == CW'(NBYTES - 1));
    assign legal     = is_legal_op(op_q, MUL_EN);

    // Single-cycle results and iterative-mode selection
    always_comb begin
        alu_res  = '0;
        mode     = IT_MUL;
        use_iter = 1'b0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_SLT:  alu_res = XLEN'($signed(a_q) < $signed(b_q));
            OP_SLTU: alu_res = XLEN'(a_q < b_q);
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_SLL:  begin mode = IT_SLL; use_iter = 1'b1; end
            OP_SRL:  begin mode = IT_SRL; use_iter = 1'b1; end
            OP_SRA:  begin mode = IT_SRA; use_iter = 1'b1; end
            OP_MUL:  begin mode = IT_MUL; use_iter = legal; end
            default: alu_res = '0;
        endcase
    end

    assign iter_start = (state_q == S_EXEC) && first_q && use_iter;
    assign exec_done  = !legal || !use_iter || iter_done;
    assign exec_res   = !legal ? '0 : (use_iter ? iter_res : alu_res);

    riscv_alu_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .mode   (mode),
        .a      (a_q),
        .b      (b_q),
        .done   (iter_done),
        .result (iter_res)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (bus.in_valid && byte_last) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (bus.in_valid && byte_last) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready && byte_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand packing, result capture and output byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            first_q <= (state_q == S_LOAD_B) && in_fire && byte_last;
            unique case (state_q)
                S_IDLE: begin
                    if (in_fire) op_q <= bus.in_data[4:0];
                end
                S_LOAD_A: begin
                    if (in_fire) begin
                        a_q[int'(bcnt_q)*8 +: 8] <= bus.in_data;
                        bcnt_q <= byte_last ? '0 : bcnt_q + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (in_fire) begin
                        b_q[int'(bcnt_q)*8 +: 8] <= bus.in_data;
                        bcnt_q <= byte_last ? '0 : bcnt_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        res_q  <= exec_res;
                        zero_q <= (exec_res == '0);
                        err_q  <= !legal;
                    end
                end
                S_OUT: begin
                    if (out_fire) bcnt_q <= byte_last ? '0 : bcnt_q + 1'b1;
                end
                default: bcnt_q <= '0;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? res_q[int'(bcnt_q)*8 +: 8] : 8'h00;
    assign bus.out_last  = out_valid && byte_last;
    assign bus.out_zero  = out_valid && zero_q;
    assign bus.out_err   = out_valid && err_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Directed bench for riscv_alu_seq at XLEN 8, 32 and 64.
// A shared driver is steered to one instance at a time through sel.
module tb_riscv_alu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int acc_cyc  = 0;
    int sel      = 32;

    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready, out_valid, out_last, out_zero, out_err, busy;
    logic [7:0] out_data;

    riscv_alu_if if8 ();
    riscv_alu_if if32 ();
    riscv_alu_if if64 ();

    riscv_alu_seq #(.XLEN(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    riscv_alu_seq #(.XLEN(32)) dut   (.clk(clk), .rst(rst), .bus(if32));
    riscv_alu_seq #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    assign if8.in_valid   = in_valid && (sel == 8);
    assign if8.in_data    = in_data;
    assign if8.out_ready  = out_ready && (sel == 8);
    assign if32.in_valid  = in_valid && (sel == 32);
    assign if32.in_data   = in_data;
    assign if32.out_ready = out_ready && (sel == 32);
    assign if64.in_valid  = in_valid && (sel == 64);
    assign if64.in_data   = in_data;
    assign if64.out_ready = out_ready && (sel == 64);

    // Route the selected instance's outputs to the checker
    always_comb begin
        in_ready  = if32.in_ready;
        out_valid = if32.out_valid;
        out_data  = if32.out_data;
        out_last  = if32.out_last;
        out_zero  = if32.out_zero;
        out_err   = if32.out_err;
        busy      = if32.busy;
        if (sel == 8) begin
            in_ready  = if8.in_ready;
            out_valid = if8.out_valid;
            out_data  = if8.out_data;
            out_last  = if8.out_last;
            out_zero  = if8.out_zero;
            out_err   = if8.out_err;
            busy      = if8.busy;
        end else if (sel == 64) begin
            in_ready  = if64.in_ready;
            out_valid = if64.out_valid;
            out_data  = if64.out_data;
            out_last  = if64.out_last;
            out_zero  = if64.out_zero;
            out_err   = if64.out_err;
            busy      = if64.busy;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one byte from a negedge and hold it until accepted
    task automatic send_byte(input logic [7:0] b);
        int  n    = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            if (in_ready) begin
                acc_cyc = cyc;
                done    = 1;
            end else if (n > 100) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                done = 1;
            end
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_txn(input logic [7:0] op, input logic [63:0] a,
                            input logic [63:0] b, input int nb);
        send_byte(op);
        for (int i = 0; i < nb; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < nb; i++) send_byte(b[8*i +: 8]);
    endtask

    // Collect nb result bytes, checking every byte each cycle it is offered
    task automatic recv(input string tag, input logic [63:0] exp,
                        input logic ez, input logic ee, input int nb,
                        input int lat, input bit stall);
        int n = 0;
        int i = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (lat >= 0) chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(lat));
        chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
        while (i < nb && n < 600) begin
            chk({tag, "_ov"},   64'(out_valid), 64'd1);
            chk({tag, "_data"}, 64'(out_data), 64'(exp[8*i +: 8]));
            chk({tag, "_last"}, 64'(out_last), 64'(i == nb - 1));
            chk({tag, "_zero"}, 64'(out_zero), 64'(ez));
            chk({tag, "_err"},  64'(out_err),  64'(ee));
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            if (out_ready) i++;
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk({tag, "_count"}, 64'(i), 64'(nb));
        chk({tag, "_end"},   64'(out_valid), 64'd0);
        chk({tag, "_idle"},  64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        sel       = 32;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_zero",  64'(out_zero),  64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        send_txn(8'h00, 64'd5, 64'd3, 4);
        recv("add", 64'h08, 1'b0, 1'b0, 4, 2, 0);

        send_txn(8'h08, 64'd0, 64'd1, 4);
        recv("sub_wrap", 64'hFFFF_FFFF, 1'b0, 1'b0, 4, 2, 0);
        send_txn(8'h08, 64'd7, 64'd7, 4);
        recv("sub_zero", 64'h0, 1'b1, 1'b0, 4, 2, 0);
        send_txn(8'hE8, 64'd10, 64'd3, 4);
        recv("sub_hibits", 64'd7, 1'b0, 1'b0, 4, 2, 0);

        send_txn(8'h0D, 64'h8000_0000, 64'h24, 4);
        recv("sra4", 64'hF800_0000, 1'b0, 1'b0, 4, 6, 0);
        send_txn(8'h01, 64'h1234_5678, 64'h20, 4);
        recv("sll0", 64'h1234_5678, 1'b0, 1'b0, 4, 2, 0);
        send_txn(8'h05, 64'h8000_0000, 64'h3, 4);
        recv("srl3", 64'h1000_0000, 1'b0, 1'b0, 4, 5, 0);
        send_txn(8'h01, 64'h1, 64'h1F, 4);
        recv("sll31", 64'h8000_0000, 1'b0, 1'b0, 4, 33, 0);

        send_txn(8'h02, 64'hFFFF_FFFF, 64'h1, 4);
        recv("slt", 64'h1, 1'b0, 1'b0, 4, 2, 0);
        send_txn(8'h03, 64'hFFFF_FFFF, 64'h1, 4);
        recv("sltu", 64'h0, 1'b1, 1'b0, 4, 2, 0);

        send_txn(8'h04, 64'hF0F0_F0F0, 64'hFF00_FF00, 4);
        recv("xor", 64'h0FF0_0FF0, 1'b0, 1'b0, 4, 2, 0);
        send_txn(8'h06, 64'hF0F0_F0F0, 64'hFF00_FF00, 4);
        recv("or", 64'hFFF0_FFF0, 1'b0, 1'b0, 4, 2, 0);
        send_txn(8'h07, 64'hF0F0_F0F0, 64'hFF00_FF00, 4);
        recv("and", 64'hF000_F000, 1'b0, 1'b0, 4, 2, 0);

        send_txn(8'h09, 64'd5, 64'd3, 4);
        recv("ill09", 64'h0, 1'b1, 1'b1, 4, 2, 0);
`ifdef RISCV_ALU_MUL_EN
        send_txn(8'h10, 64'd7, 64'd6, 4);
        recv("mul", 64'h2A, 1'b0, 1'b0, 4, 34, 0);
        send_txn(8'h10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4);
        recv("mul_wrap", 64'h1, 1'b0, 1'b0, 4, 34, 0);
`else
        send_txn(8'h10, 64'd7, 64'd6, 4);
        recv("ill10", 64'h0, 1'b1, 1'b1, 4, 2, 0);
`endif

        send_txn(8'h00, 64'h1122_3344, 64'h0101_0101, 4);
        recv("stall", 64'h1223_3445, 1'b0, 1'b0, 4, 2, 1);

        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",  64'(busy),     64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_noout", 64'(out_valid), 64'd0);
        end
        send_txn(8'h00, 64'd5, 64'd3, 4);
        recv("after_rst", 64'h08, 1'b0, 1'b0, 4, 2, 0);

        sel = 8;
        @(negedge clk);
        send_txn(8'h00, 64'd5, 64'd3, 1);
        recv("add8", 64'h08, 1'b0, 1'b0, 1, 2, 0);
        send_txn(8'h0D, 64'h80, 64'hFB, 1);
        recv("sra8", 64'hF0, 1'b0, 1'b0, 1, 5, 0);

        sel = 64;
        @(negedge clk);
        send_txn(8'h00, 64'd5, 64'd3, 8);
        recv("add64", 64'h08, 1'b0, 1'b0, 8, 2, 0);
        send_txn(8'h00, 64'hFFFF_FFFF, 64'd1, 8);
        recv("add64_c", 64'h1_0000_0000, 1'b0, 1'b0, 8, 2, 0);
        send_txn(8'h0D, 64'h8000_0000_0000_0000, 64'h3F, 8);
        recv("sra64", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 8, 65, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
